// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-boundary registers: slot state encoding
// and the default field widths of the ID/EX boundary.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam int ID_EX_CTRL_W = 7;
    localparam int ID_EX_DATA_W = 111;
    localparam int ID_EX_CNT_W  = 16;

    // The stage can take a new beat unless the skid slot will be occupied.
    function automatic logic ready_for_state(input logic [1:0] st);
        return (st != ST_SKID);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One {valid, ctrl, data} storage slot. Clearing kills the beat and zeroes
// ctrl so a bubble is harmless downstream; data is kept as-is.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Slot storage; clear wins over load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            ctrl_r  <= {CTRL_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
        end else if (clear) begin
            valid_r <= 1'b0;
            ctrl_r  <= {CTRL_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            ctrl_r  <= ld_ctrl;
            data_r  <= ld_data;
        end
    end

    assign valid = valid_r;
    assign ctrl  = ctrl_r;
    assign data  = data_r;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake with a one-entry skid
// buffer, bubble-inserting flush and a saturating stall counter.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CNT_W  = ID_EX_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              in_ready_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              in_fire_s;
    logic              main_load_s;
    logic              main_clear_s;
    logic              main_from_skid_s;
    logic              skid_load_s;
    logic              skid_clear_s;

    logic              main_valid_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [DATA_W-1:0] main_data_s;
    logic              skid_valid_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;
    logic [CTRL_W-1:0] main_ld_ctrl_s;
    logic [DATA_W-1:0] main_ld_data_s;

    assign in_fire_s = in_valid_i & in_ready_r;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and slot controls; flush overrides every handshake.
    always_comb begin
        state_nxt_s      = state_r;
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (flush_i) begin
            state_nxt_s  = ST_EMPTY;
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = ST_FULL;
                        main_load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready_i && in_fire_s) begin
                        main_load_s = 1'b1;
                    end else if (out_ready_i) begin
                        state_nxt_s  = ST_EMPTY;
                        main_clear_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_nxt_s = ST_SKID;
                        skid_load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // Order is kept by refilling MAIN from SKID, never from the input.
                    if (out_ready_i) begin
                        state_nxt_s      = ST_FULL;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_SKID;
                    end
                end
                default: begin
                    state_nxt_s  = ST_EMPTY;
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    assign main_ld_ctrl_s = main_from_skid_s ? skid_ctrl_s : in_ctrl_i;
    assign main_ld_data_s = main_from_skid_s ? skid_data_s : in_data_i;

    // Ready is computed from the next state so out_ready_i never reaches in_ready_o combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= ready_for_state(state_nxt_s);
        end
    end

    // Saturating count of cycles where EX holds off a valid beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (main_valid_s && !out_ready_i && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (main_load_s),
        .clear   (main_clear_s),
        .ld_ctrl (main_ld_ctrl_s),
        .ld_data (main_ld_data_s),
        .valid   (main_valid_s),
        .ctrl    (main_ctrl_s),
        .data    (main_data_s)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (skid_load_s),
        .clear   (skid_clear_s),
        .ld_ctrl (in_ctrl_i),
        .ld_data (in_data_i),
        .valid   (skid_valid_s),
        .ctrl    (skid_ctrl_s),
        .data    (skid_data_s)
    );

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = main_valid_s;
    assign out_ctrl_o  = main_ctrl_s;
    assign out_data_o  = main_data_s;
    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed checks of streaming, back-pressure, flush, saturation and reset,
// followed by a random run against a reference queue model.
module tb_id_ex_pipe_reg;

    localparam int CW = 7;
    localparam int DW = 111;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] exp_hold;
    logic [NW-1:0] exp_stall;
    logic          exp_ready;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_ctrl_i   (in_ctrl),
        .in_data_i   (in_data),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_ctrl_o  (out_ctrl),
        .out_data_o  (out_data),
        .stall_cnt_o (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input logic [CW-1:0] c);
        return {32'hC0DE_0000, 72'd0, c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [CW-1:0] c);
        in_valid = v;
        in_ctrl  = c;
        in_data  = dat(c);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        send(1'b0, 7'h00);
        step(); step();
        rst = 1'b0;
        check_eq("rst_valid", 128'(out_valid), 128'd0);
        check_eq("rst_ctrl",  128'(out_ctrl),  128'd0);
        check_eq("rst_data",  128'(out_data),  128'd0);
        check_eq("rst_ready", 128'(in_ready),  128'd1);
        check_eq("rst_stall", 128'(stall_cnt), 128'd0);

        // streaming
        out_ready = 1'b1;
        send(1'b1, 7'h15); step();
        check_eq("str_valid0", 128'(out_valid), 128'd1);
        check_eq("str_ctrl0",  128'(out_ctrl),  128'h15);
        check_eq("str_ready0", 128'(in_ready),  128'd1);
        send(1'b1, 7'h2A); step();
        check_eq("str_ctrl1",  128'(out_ctrl),  128'h2A);
        check_eq("str_data1",  128'(out_data),  128'(dat(7'h2A)));
        check_eq("str_ready1", 128'(in_ready),  128'd1);
        check_eq("str_stall",  128'(stall_cnt), 128'd0);
        send(1'b0, 7'h00); step();
        check_eq("str_idle_valid", 128'(out_valid), 128'd0);
        check_eq("str_idle_ctrl",  128'(out_ctrl),  128'd0);
        check_eq("str_idle_data",  128'(out_data),  128'(dat(7'h2A)));

        // back-pressure A,B,C
        out_ready = 1'b0;
        send(1'b1, 7'h01); step();
        check_eq("bp_a_ctrl",  128'(out_ctrl), 128'h01);
        check_eq("bp_a_ready", 128'(in_ready), 128'd1);
        send(1'b1, 7'h02); step();
        check_eq("bp_b_hold",  128'(out_ctrl), 128'h01);
        check_eq("bp_b_ready", 128'(in_ready), 128'd0);
        send(1'b1, 7'h03); step();
        check_eq("bp_c_hold",  128'(out_ctrl),  128'h01);
        check_eq("bp_c_ready", 128'(in_ready),  128'd0);
        check_eq("bp_stall",   128'(stall_cnt), 128'd2);
        out_ready = 1'b1; step();
        check_eq("bp_out_b",   128'(out_ctrl), 128'h02);
        check_eq("bp_ready_b", 128'(in_ready), 128'd1);
        step();
        check_eq("bp_out_c",   128'(out_ctrl), 128'h03);
        check_eq("bp_data_c",  128'(out_data), 128'(dat(7'h03)));
        send(1'b0, 7'h00); step();
        check_eq("bp_empty",   128'(out_valid), 128'd0);

        // flush while in SKID with an incoming beat
        out_ready = 1'b0;
        send(1'b1, 7'h11); step();
        send(1'b1, 7'h12); step();
        check_eq("fl_pre_ready", 128'(in_ready), 128'd0);
        flush = 1'b1;
        send(1'b1, 7'h13); step();
        flush = 1'b0;
        check_eq("fl_valid", 128'(out_valid), 128'd0);
        check_eq("fl_ctrl",  128'(out_ctrl),  128'd0);
        check_eq("fl_ready", 128'(in_ready),  128'd1);
        check_eq("fl_data",  128'(out_data),  128'(dat(7'h11)));
        check_eq("fl_stall", 128'(stall_cnt), 128'd4);
        send(1'b0, 7'h00); out_ready = 1'b1; step();
        check_eq("fl_nothing", 128'(out_valid), 128'd0);

        // stall counter saturation
        out_ready = 1'b0;
        send(1'b1, 7'h21); step();
        send(1'b0, 7'h00);
        for (int i = 0; i < 20; i++) step();
        check_eq("sat_stall", 128'(stall_cnt), 128'd15);
        check_eq("sat_valid", 128'(out_valid), 128'd1);
        flush = 1'b1; step(); flush = 1'b0;
        check_eq("sat_flush_stall", 128'(stall_cnt), 128'd15);
        check_eq("sat_flush_valid", 128'(out_valid), 128'd0);

        // reset while in SKID
        send(1'b1, 7'h31); step();
        send(1'b1, 7'h32); step();
        check_eq("rs_pre_ready", 128'(in_ready), 128'd0);
        send(1'b0, 7'h00);
        rst = 1'b1; step(); rst = 1'b0;
        check_eq("rs_valid", 128'(out_valid), 128'd0);
        check_eq("rs_ctrl",  128'(out_ctrl),  128'd0);
        check_eq("rs_data",  128'(out_data),  128'd0);
        check_eq("rs_ready", 128'(in_ready),  128'd1);
        check_eq("rs_stall", 128'(stall_cnt), 128'd0);
        out_ready = 1'b1;
        send(1'b1, 7'h41); step();
        check_eq("rs_first_valid", 128'(out_valid), 128'd1);
        check_eq("rs_first_ctrl",  128'(out_ctrl),  128'h41);
        check_eq("rs_first_data",  128'(out_data),  128'(dat(7'h41)));
        send(1'b0, 7'h00); step();
        check_eq("rs_drain", 128'(out_valid), 128'd0);

        // random run against a two-deep queue model
        q.delete();
        exp_hold  = dat(7'h41);
        exp_stall = 4'd0;
        exp_ready = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(15) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = {32'hBEEF_0000, 47'd0, 32'(n)};
            if ((q.size() > 0) && !out_ready && (exp_stall != 4'd15)) exp_stall++;
            if ((q.size() > 0) && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && exp_ready) q.push_back('{c: in_ctrl, d: in_data});
            if (q.size() > 0) exp_hold = q[0].d;
            exp_ready = (q.size() != 2);
            step();
            check_eq("rnd_valid", 128'(out_valid), 128'(q.size() > 0));
            check_eq("rnd_ctrl",  128'(out_ctrl),  (q.size() > 0) ? 128'(q[0].c) : 128'd0);
            check_eq("rnd_data",  128'(out_data),  128'(exp_hold));
            check_eq("rnd_ready", 128'(in_ready),  128'(exp_ready));
            check_eq("rnd_stall", 128'(stall_cnt), 128'(exp_stall));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
